trace_stream_packer: RTL and testbench

- Consumer end of the trace filter interface. Takes each instruction the filter keeps (pc_valid=1, drop_instr=0) together with its PC.
- Buffers kept instructions in a FIFO and emits them as AXI-Stream-style items with packet framing.
- Counts items lost to backpressure and flags the first item after a loss.
- Sits between trace_filter and the host/DMA transfer path.

---
 rtl/trace_stream_packer.sv | 110 +++++++++++
 tb/tb_trace_stream_packer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/trace_stream_packer.sv
// Buffers instructions kept by trace_filter in a FWFT FIFO and emits them as framed stream items.
// Optional define TRACE_STREAM_PACKER_TIMESTAMP_EN adds a 32-bit cycle timestamp above the gap bit.
module trace_stream_packer #(
   parameter int PC_WIDTH          = 64,
   parameter int FIFO_DEPTH        = 16,
   parameter int PACKET_ITEMS      = 8,
   parameter int OVF_COUNTER_WIDTH = 16,
   localparam int TS_W =
`ifdef TRACE_STREAM_PACKER_TIMESTAMP_EN
      32,
`else
      0,
`endif
   localparam int DATA_W = 1 + PC_WIDTH + 32 + TS_W,
   localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         pc_valid,
   input  logic                         drop_instr,
   input  logic [PC_WIDTH-1:0]          pc,
   input  logic [31:0]                  instr,
   output logic                         m_tvalid,
   input  logic                         m_tready,
   output logic [DATA_W-1:0]            m_tdata,
   output logic                         m_tlast,
   output logic [LVL_W-1:0]             fifo_level,
   output logic [OVF_COUNTER_WIDTH-1:0] overflow_count,
   output logic                         overflow_sticky
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int PKT_W = (PACKET_ITEMS > 1) ? $clog2(PACKET_ITEMS) : 1;
   localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(FIFO_DEPTH);
   localparam logic [PKT_W-1:0] LAST_PKT   = PKT_W'(PACKET_ITEMS - 1);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [LVL_W-1:0]  level;
   logic [PKT_W-1:0]  pkt_cnt;
   logic              gap_pending;
   logic              push_req;
   logic              pop;
   logic              full;
   logic              push_ok;
   logic              overflow;
   logic [DATA_W-1:0] item;

   assign push_req = pc_valid & ~drop_instr;
   assign m_tvalid = (level != '0);
   assign pop      = m_tvalid & m_tready;
   assign full     = (level == FULL_LEVEL);
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign push_ok  = push_req & (~full | pop);
   assign overflow = push_req & full & ~pop;

`ifdef TRACE_STREAM_PACKER_TIMESTAMP_EN
   logic [31:0] ts_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ts_cnt <= '0;
      else     ts_cnt <= ts_cnt + 32'd1;
   end

   assign item = {ts_cnt, gap_pending, pc, instr};
`else
   assign item = {gap_pending, pc, instr};
`endif

   // Head is forced to zero while empty so stale storage never shows on the bus.
   assign m_tdata    = m_tvalid ? mem[rd_ptr] : '0;
   assign m_tlast    = m_tvalid & (pkt_cnt == LAST_PKT);
   assign fifo_level = level;

   // NOTE: storage has no reset; level gates visibility, so clearing the array buys nothing.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= item;
   end

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         level           <= '0;
         pkt_cnt         <= '0;
         gap_pending     <= 1'b0;
         overflow_count  <= '0;
         overflow_sticky <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);

         if (push_ok & ~pop)      level <= level + LVL_W'(1);
         else if (~push_ok & pop) level <= level - LVL_W'(1);

         if (pop) pkt_cnt <= (pkt_cnt == LAST_PKT) ? '0 : pkt_cnt + PKT_W'(1);

         if (overflow) begin
            gap_pending     <= 1'b1;
            overflow_sticky <= 1'b1;
            if (overflow_count != '1) overflow_count <= overflow_count + OVF_COUNTER_WIDTH'(1);
         end else if (push_ok) begin
            gap_pending <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_trace_stream_packer.sv
// Directed bench for trace_stream_packer (FIFO_DEPTH=4, PACKET_ITEMS=4): vector table plus
// hand-written reset and framing sequences.
module tb_trace_stream_packer;

   localparam int PC_W = 64;
`ifdef TRACE_STREAM_PACKER_TIMESTAMP_EN
   localparam int TS_W = 32;
`else
   localparam int TS_W = 0;
`endif
   localparam int DATA_W = 1 + PC_W + 32 + TS_W;
   localparam int NVEC   = 18;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              pc_valid = 1'b0;
   logic              drop_instr = 1'b0;
   logic [PC_W-1:0]   pc = '0;
   logic [31:0]       instr = '0;
   logic              m_tvalid;
   logic              m_tready = 1'b0;
   logic [DATA_W-1:0] m_tdata;
   logic              m_tlast;
   logic [2:0]        fifo_level;
   logic [15:0]       overflow_count;
   logic              overflow_sticky;

   int checks = 0;
   int errors = 0;

   trace_stream_packer #(
      .PC_WIDTH(PC_W), .FIFO_DEPTH(4), .PACKET_ITEMS(4), .OVF_COUNTER_WIDTH(16)
   ) dut (
      .clk(clk), .rst(rst), .pc_valid(pc_valid), .drop_instr(drop_instr), .pc(pc),
      .instr(instr), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
      .m_tlast(m_tlast), .fifo_level(fifo_level), .overflow_count(overflow_count),
      .overflow_sticky(overflow_sticky)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        pv, drop, rdy;
      logic [63:0] pc;
      logic [31:0] ins;
      logic        ev, el;
      logic [2:0]  elvl;
      logic [15:0] eovf;
      logic        es, eg;
      logic [63:0] epc;
      logic [31:0] ei;
   } vec_t;

   vec_t vecs [NVEC];

   function automatic vec_t mk(input logic pv, input logic drop, input logic rdy,
                               input logic [63:0] p, input logic [31:0] i,
                               input logic ev, input logic el, input int elvl, input int eovf,
                               input logic es, input logic eg, input logic [63:0] epc,
                               input logic [31:0] ei);
      vec_t v;
      v.pv = pv; v.drop = drop; v.rdy = rdy; v.pc = p; v.ins = i;
      v.ev = ev; v.el = el; v.elvl = 3'(elvl); v.eovf = 16'(eovf);
      v.es = es; v.eg = eg; v.epc = epc; v.ei = ei;
      return v;
   endfunction

   // gap, pc and instr occupy the low bits in both builds
   function automatic logic [96:0] payload();
      return m_tdata[96:0];
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic pv, input logic drop, input logic rdy,
                        input logic [63:0] p, input logic [31:0] i);
      pc_valid = pv; drop_instr = drop; m_tready = rdy; pc = p; instr = i;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] status();
      return 128'({m_tvalid, m_tlast, fifo_level, payload()});
   endfunction

   initial begin
      // pass-through
      vecs[0]  = mk(1,0,1, 64'h1000, 32'h00000013, 1,0,1,0, 0,0, 64'h1000, 32'h00000013);
      vecs[1]  = mk(1,0,1, 64'h1004, 32'h00029663, 1,0,1,0, 0,0, 64'h1004, 32'h00029663);
      vecs[2]  = mk(0,0,1, 64'h0,    32'h0,        0,0,0,0, 0,0, 64'h0,    32'h0);
      // filtered instructions never push
      vecs[3]  = mk(1,1,1, 64'h1008, 32'h00000013, 0,0,0,0, 0,0, 64'h0,    32'h0);
      vecs[4]  = mk(1,1,1, 64'h100C, 32'h00000013, 0,0,0,0, 0,0, 64'h0,    32'h0);
      vecs[5]  = mk(1,1,1, 64'h1010, 32'h00000013, 0,0,0,0, 0,0, 64'h0,    32'h0);
      vecs[6]  = mk(0,0,1, 64'h1014, 32'h00000013, 0,0,0,0, 0,0, 64'h0,    32'h0);
      // backpressure: A..D stored, E and F dropped (pkt_cnt is 2 here)
      vecs[7]  = mk(1,0,0, 64'h2000, 32'hA0, 1,0,1,0, 0,0, 64'h2000, 32'hA0);
      vecs[8]  = mk(1,0,0, 64'h2004, 32'hA1, 1,0,2,0, 0,0, 64'h2000, 32'hA0);
      vecs[9]  = mk(1,0,0, 64'h2008, 32'hA2, 1,0,3,0, 0,0, 64'h2000, 32'hA0);
      vecs[10] = mk(1,0,0, 64'h200C, 32'hA3, 1,0,4,0, 0,0, 64'h2000, 32'hA0);
      vecs[11] = mk(1,0,0, 64'h2010, 32'hA4, 1,0,4,1, 1,0, 64'h2000, 32'hA0);
      vecs[12] = mk(1,0,0, 64'h2014, 32'hA5, 1,0,4,2, 1,0, 64'h2000, 32'hA0);
      // full with simultaneous pop: G accepted, level stays 4, B is 4th of packet
      vecs[13] = mk(1,0,1, 64'h2018, 32'hA6, 1,1,4,2, 1,0, 64'h2004, 32'hA1);
      vecs[14] = mk(0,0,1, 64'h0,    32'h0,  1,0,3,2, 1,0, 64'h2008, 32'hA2);
      vecs[15] = mk(0,0,1, 64'h0,    32'h0,  1,0,2,2, 1,0, 64'h200C, 32'hA3);
      vecs[16] = mk(0,0,1, 64'h0,    32'h0,  1,0,1,2, 1,1, 64'h2018, 32'hA6);
      vecs[17] = mk(0,0,1, 64'h0,    32'h0,  0,0,0,2, 1,0, 64'h0,    32'h0);

      #1;
      check("reset_state", 128'({m_tvalid, m_tlast, fifo_level, overflow_sticky, overflow_count, payload()}), 128'(0));
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         drive(vecs[i].pv, vecs[i].drop, vecs[i].rdy, vecs[i].pc, vecs[i].ins);
         check($sformatf("vec%0d", i),
               128'({m_tvalid, m_tlast, fifo_level, overflow_sticky, overflow_count, payload()}),
               128'({vecs[i].ev, vecs[i].el, vecs[i].elvl, vecs[i].es, vecs[i].eovf,
                     vecs[i].eg, vecs[i].epc, vecs[i].ei}));
      end

      // build up pkt_cnt=2 with three items buffered (pkt_cnt starts at 3)
      drive(1,0,1, 64'h4000, 32'hC0); check("pre_r0", status(), 128'({1'b1,1'b1,3'd1,1'b0,64'h4000,32'hC0}));
      drive(1,0,1, 64'h4004, 32'hC1); check("pre_r1", status(), 128'({1'b1,1'b0,3'd1,1'b0,64'h4004,32'hC1}));
      drive(1,0,1, 64'h4008, 32'hC2); check("pre_r2", status(), 128'({1'b1,1'b0,3'd1,1'b0,64'h4008,32'hC2}));
      drive(1,0,1, 64'h400C, 32'hC3); check("pre_r3", status(), 128'({1'b1,1'b0,3'd1,1'b0,64'h400C,32'hC3}));
      drive(1,0,0, 64'h4010, 32'hC4); check("pre_r4", status(), 128'({1'b1,1'b0,3'd2,1'b0,64'h400C,32'hC3}));
      drive(1,0,0, 64'h4014, 32'hC5); check("pre_r5", status(), 128'({1'b1,1'b0,3'd3,1'b0,64'h400C,32'hC3}));

      // asynchronous reset between edges
      pc_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("rst_async", 128'({m_tvalid, m_tlast, fifo_level, overflow_sticky, overflow_count, payload()}), 128'(0));
      @(posedge clk);
      #1;
      check("rst_hold", 128'({m_tvalid, m_tlast, fifo_level, overflow_sticky, overflow_count, payload()}), 128'(0));
      @(negedge clk);
      rst = 1'b0;

      drive(1,0,0, 64'h5000, 32'hD0);
      check("post_t0", status(), 128'({1'b1,1'b0,3'd1,1'b0,64'h5000,32'hD0}));
`ifdef TRACE_STREAM_PACKER_TIMESTAMP_EN
      check("post_ts0", 128'(m_tdata[DATA_W-1 -: 32]), 128'(0));
`endif
      drive(1,0,0, 64'h5004, 32'hD1); check("post_t1", status(), 128'({1'b1,1'b0,3'd2,1'b0,64'h5000,32'hD0}));
      drive(1,0,0, 64'h5008, 32'hD2); check("post_t2", status(), 128'({1'b1,1'b0,3'd3,1'b0,64'h5000,32'hD0}));
      drive(1,0,0, 64'h500C, 32'hD3);
      check("post_t3", 128'({status(), overflow_sticky, overflow_count}), 128'({1'b1,1'b0,3'd4,1'b0,64'h5000,32'hD0,1'b0,16'd0}));
      drive(0,0,1, 64'h0, 32'h0); check("post_pop0", status(), 128'({1'b1,1'b0,3'd3,1'b0,64'h5004,32'hD1}));
      drive(0,0,1, 64'h0, 32'h0); check("post_pop1", status(), 128'({1'b1,1'b0,3'd2,1'b0,64'h5008,32'hD2}));
      drive(0,0,1, 64'h0, 32'h0); check("post_pop2", status(), 128'({1'b1,1'b1,3'd1,1'b0,64'h500C,32'hD3}));
      drive(0,0,1, 64'h0, 32'h0); check("post_pop3", status(), 128'(0));

      // framing: ready toggles each cycle, 9 items, tlast on the 4th and 8th only
      begin
         logic [96:0] q [$];
         logic [96:0] held;
         logic        held_last;
         logic        stall;
         int          sent;
         int          rcv;
         stall = 1'b0; sent = 0; rcv = 0; held = '0; held_last = 1'b0;
         for (int cyc = 0; cyc < 60 && rcv < 9; cyc++) begin
            if (stall) check("frame_hold", 128'({m_tlast, payload()}), 128'({held_last, held}));
            if (m_tvalid) begin
               check($sformatf("frame_data%0d", rcv), 128'(payload()), 128'(q.size() > 0 ? q[0] : 97'd0));
               check($sformatf("frame_last%0d", rcv), 128'(m_tlast), 128'((rcv % 4) == 3));
            end
            m_tready  = (cyc % 2 == 0);
            stall     = m_tvalid & ~m_tready;
            held      = payload();
            held_last = m_tlast;
            if (m_tvalid && m_tready) begin
               rcv++;
               if (q.size() > 0) void'(q.pop_front());
            end
            pc_valid   = (sent < 9) && (cyc % 2 == 0);
            drop_instr = 1'b0;
            pc         = 64'h3000 + 64'(4 * sent);
            instr      = 32'hB0 + 32'(sent);
            if (pc_valid) begin
               q.push_back({1'b0, pc, instr});
               sent++;
            end
            @(posedge clk);
            #1;
         end
         check("frame_count", 128'(rcv), 128'(9));
         check("frame_ovf", 128'(overflow_count), 128'(0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
